// File: rtl/video_io_responder_pkg.sv
// Shared register map, shadow byte indices and FLAGS bit layout for the
// video I/O responder.
package video_io_responder_pkg;

    localparam logic [7:0] ADDR_HPOS        = 8'h40;
    localparam logic [7:0] ADDR_VPOS        = 8'h41;
    localparam logic [7:0] ADDR_FLAGS       = 8'h42;
    localparam logic [7:0] ADDR_PADDLE_X    = 8'h43;
    localparam logic [7:0] ADDR_PADDLE_Y    = 8'h44;
    localparam logic [7:0] ADDR_FRAME       = 8'h45;
    localparam logic [7:0] ADDR_COLLIDE_CLR = 8'h46;

    localparam logic [5:0] SH_PLAYER_X    = 6'd2;
    localparam logic [5:0] SH_PLAYER_Y    = 6'd3;
    localparam logic [5:0] SH_ENEMY_X     = 6'd4;
    localparam logic [5:0] SH_ENEMY_Y     = 6'd5;
    localparam logic [5:0] SH_TRACKPOS_LO = 6'd8;

    localparam int FLAG_DISPLAY_ON   = 0;
    localparam int FLAG_HPADDLE      = 1;
    localparam int FLAG_VPADDLE      = 2;
    localparam int FLAG_HSYNC        = 3;
    localparam int FLAG_VSYNC        = 4;
    localparam int FLAG_COLLIDE      = 5;
    localparam int FLAG_PADDLE_VALID = 6;

    function automatic logic is_ram_addr(input logic [7:0] addr);
        return addr[7:6] == 2'b00;
    endfunction

endpackage

// File: rtl/video_io_responder_paddle_capture.sv
// One paddle channel: captures a beam coordinate on the first rising edge
// of the paddle comparator after each frame start.
module paddle_capture (
    input  logic       clk,
    input  logic       reset,
    input  logic       edge_src_i,
    input  logic [7:0] cap_val_i,
    input  logic       frame_start_i,
    output logic [7:0] value_o,
    output logic       captured_o
);
    logic       prev_q, armed_q, armed_d;
    logic [7:0] value_q, value_d;

    // Frame start takes priority: an edge in that cycle only re-arms.
    assign captured_o = armed_q && edge_src_i && !prev_q && !frame_start_i;

    always_comb begin
        armed_d = armed_q;
        value_d = value_q;
        if (frame_start_i) begin
            armed_d = 1'b1;
        end else if (captured_o) begin
            armed_d = 1'b0;
            value_d = cap_val_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            value_q <= 8'h00;
        end else begin
            prev_q  <= edge_src_i;
            armed_q <= armed_d;
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/video_io_responder.sv
// CPU-facing video I/O block: scratch RAM, beam/flag readback, paddle and
// collision capture, frame counter and vsync-latched sprite shadows.
module video_io_responder
    import video_io_responder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] address_bus,
    input  logic [7:0] from_cpu,
    input  logic       write_enable,
    output logic [7:0] to_cpu,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       display_on,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       hpaddle,
    input  logic       vpaddle,
    input  logic       player_gfx,
    input  logic       enemy_gfx,
    input  logic       track_gfx,
    output logic [7:0] player_x,
    output logic [7:0] player_y,
    output logic [7:0] enemy_x,
    output logic [7:0] enemy_y,
    output logic [7:0] trackpos_lo
);
    logic [7:0] ram_q [0:63];
    logic       frame_start, ram_we, collide_clr, hit, vsync_fall;
    logic       collide_live_q, collide_live_d, collide_rep_q, collide_rep_d;
    logic       paddle_valid_q, paddle_valid_d, vsync_prev_q;
    logic [7:0] frame_q, paddle_x, paddle_y, flags;
    logic       cap_x, cap_y_unused;
    logic [7:0] player_x_q, player_y_q, enemy_x_q, enemy_y_q, trackpos_lo_q;

    assign frame_start = (hpos == 9'd0) && (vpos == 9'd0);
    assign ram_we      = write_enable && is_ram_addr(address_bus);
    assign collide_clr = write_enable && (address_bus == ADDR_COLLIDE_CLR);
    assign hit         = display_on && player_gfx && (enemy_gfx || track_gfx);
    assign vsync_fall  = vsync_prev_q && !vsync;

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[address_bus[5:0]] <= from_cpu;
    end

    paddle_capture u_paddle_x (
        .clk(clk), .reset(reset), .edge_src_i(hpaddle), .cap_val_i(vpos[7:0]),
        .frame_start_i(frame_start), .value_o(paddle_x), .captured_o(cap_x)
    );

    paddle_capture u_paddle_y (
        .clk(clk), .reset(reset), .edge_src_i(vpaddle), .cap_val_i(hpos[7:0]),
        .frame_start_i(frame_start), .value_o(paddle_y), .captured_o(cap_y_unused)
    );

    // Frame start wins over both new hits and CPU clears.
    always_comb begin
        collide_live_d = collide_live_q | hit;
        collide_rep_d  = collide_clr ? 1'b0 : collide_rep_q;
        paddle_valid_d = cap_x ? 1'b1 : paddle_valid_q;
        if (frame_start) begin
            collide_live_d = 1'b0;
            collide_rep_d  = collide_live_q;
            paddle_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collide_live_q <= 1'b0;
            collide_rep_q  <= 1'b0;
            paddle_valid_q <= 1'b0;
            frame_q        <= 8'h00;
            vsync_prev_q   <= 1'b0;
            player_x_q     <= 8'h00;
            player_y_q     <= 8'h00;
            enemy_x_q      <= 8'h00;
            enemy_y_q      <= 8'h00;
            trackpos_lo_q  <= 8'h00;
        end else begin
            collide_live_q <= collide_live_d;
            collide_rep_q  <= collide_rep_d;
            paddle_valid_q <= paddle_valid_d;
            vsync_prev_q   <= vsync;
            if (frame_start) frame_q <= frame_q + 8'd1;
            // RAM is sampled before any same-cycle write lands.
            if (vsync_fall) begin
                player_x_q    <= ram_q[SH_PLAYER_X];
                player_y_q    <= ram_q[SH_PLAYER_Y];
                enemy_x_q     <= ram_q[SH_ENEMY_X];
                enemy_y_q     <= ram_q[SH_ENEMY_Y];
                trackpos_lo_q <= ram_q[SH_TRACKPOS_LO];
            end
        end
    end

    always_comb begin
        flags                    = 8'h00;
        flags[FLAG_DISPLAY_ON]   = display_on;
        flags[FLAG_HPADDLE]      = hpaddle;
        flags[FLAG_VPADDLE]      = vpaddle;
        flags[FLAG_HSYNC]        = hsync;
        flags[FLAG_VSYNC]        = vsync;
        flags[FLAG_COLLIDE]      = collide_rep_q;
        flags[FLAG_PADDLE_VALID] = paddle_valid_q;
    end

    always_comb begin
        to_cpu = 8'h00;
        if (is_ram_addr(address_bus)) begin
            to_cpu = ram_q[address_bus[5:0]];
        end else begin
            case (address_bus)
                ADDR_HPOS:     to_cpu = hpos[7:0];
                ADDR_VPOS:     to_cpu = vpos[7:0];
                ADDR_FLAGS:    to_cpu = flags;
                ADDR_PADDLE_X: to_cpu = paddle_x;
                ADDR_PADDLE_Y: to_cpu = paddle_y;
                ADDR_FRAME:    to_cpu = frame_q;
                default:       to_cpu = 8'h00;
            endcase
        end
    end

    assign player_x    = player_x_q;
    assign player_y    = player_y_q;
    assign enemy_x     = enemy_x_q;
    assign enemy_y     = enemy_y_q;
    assign trackpos_lo = trackpos_lo_q;

endmodule

// File: doc/video_io_responder.md
VIDEO_IO_RESPONDER -- requirements
Module: video_io_responder

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: address_bus  input  8  CPU address.
REQ-004 SHALL have port: from_cpu  input  8  CPU write data.
REQ-005 SHALL have port: write_enable  input  1  CPU write strobe, one cycle per write.
REQ-006 SHALL have port: to_cpu  output  8  read data, combinational from address_bus and state.
REQ-007 SHALL have ports: hpos, vpos  input  9 each  beam position from the sync generator.
REQ-008 SHALL have ports: display_on, hsync, vsync, hpaddle, vpaddle  input  1 each.
REQ-009 SHALL have ports: player_gfx, enemy_gfx, track_gfx  input  1 each  per-pixel object hits.
REQ-010 SHALL have ports: player_x, player_y, enemy_x, enemy_y, trackpos_lo  output  8 each  frame-stable shadow copies of RAM bytes 2, 3, 4, 5, 8.

Function
REQ-011 SHALL decode reads:
- 0x00-0x3F: RAM[addr[5:0]]
- 0x40: hpos[7:0]
- 0x41: vpos[7:0]
- 0x42: FLAGS
- 0x43: PADDLE_X capture
- 0x44: PADDLE_Y capture
- 0x45: FRAME counter
- all other addresses: 0x00 (ROM mux lives outside this block).
REQ-012 SHALL form FLAGS as {1'b0, paddle_valid, collide_rep, vsync, hsync, vpaddle, hpaddle, display_on}, MSB first.
REQ-013 SHALL, on write_enable with addr[7:6]==2'b00, write from_cpu into RAM[addr[5:0]] at the clock edge; a read of that byte in the same cycle returns the old value.
REQ-014 SHALL clear collide_rep on a write to 0x46, regardless of data; writes to 0x40-0x45, 0x47-0x7F and 0x80-0xFF SHALL have no effect.
REQ-015 SHALL define frame_start as the cycle where hpos==0 and vpos==0.
REQ-016 SHALL set collide_live in any cycle with display_on && player_gfx && (enemy_gfx || track_gfx); the flag is sticky within a frame.
REQ-017 SHALL, at frame_start, copy collide_live into collide_rep and clear collide_live.
- A hit in the frame_start cycle itself is lost.
- If frame_start coincides with a write to 0x46, the frame_start copy wins.
REQ-018 SHALL capture paddle positions through an arm bit that is set at frame_start:
- On the first 0->1 edge of hpaddle while armed, capture vpos[7:0] into PADDLE_X.
- Edges are detected against a registered copy of the input.
- Further edges in the same frame are ignored.
REQ-019 SHALL capture hpos[7:0] into PADDLE_Y on the first 0->1 edge of vpaddle per frame, using the same arm rule as REQ-018.
REQ-020 SHALL keep a paddle's previous capture if no edge occurs in a frame.
REQ-021 SHALL set paddle_valid when PADDLE_X is captured and clear it at frame_start; if an edge and frame_start coincide, paddle_valid SHALL end up cleared.
REQ-022 SHALL increment FRAME by 1 at each frame_start, wrapping 0xFF->0x00.
REQ-023 SHALL update the shadow outputs only in the cycle after a vsync 1->0 edge, copying RAM bytes 2, 3, 4, 5, 8.
- A CPU write to a shadowed byte in that same cycle is not seen until the next frame.
- Between updates the shadow outputs SHALL hold.
REQ-024 SHALL add no latency to to_cpu; all captures and copies take effect one clock after the triggering condition.

Reset
REQ-025 SHALL, while reset is high, force to 0: shadow outputs, PADDLE_X, PADDLE_Y, FRAME, collide_live, collide_rep, paddle_valid, arm bits and edge-detect registers.
REQ-026 SHALL not reset RAM contents; a reset mid-frame SHALL leave all captures disarmed until the next frame_start.

Structure
REQ-027 SHALL take from a shared package: the address constants (0x40-0x46, shadow byte indices 2/3/4/5/8) and the FLAGS bit positions.
REQ-028 SHALL implement each paddle channel as one instance of sub-module paddle_capture (inputs: edge source, capture value, frame_start; outputs: value, captured pulse), instantiated twice.

Verification
REQ-029 SHALL cover: write 0x5A to 0x07, then read 0x07 -> 0x5A; write 0x77 to 0x43 -> PADDLE_X unchanged; read 0x90 -> 0x00.
REQ-030 SHALL cover: hpaddle rises at vpos=100, rises again at vpos=150 in the same frame -> PADDLE_X=100, FLAGS bit6=1; at the next frame_start, bit6=0 and PADDLE_X still 100.
REQ-031 SHALL cover: player_gfx && track_gfx with display_on for one pixel in frame N -> FLAGS bit5=0 during N and 1 during N+1; write to 0x46 during N+1 -> bit5=0.
REQ-032 SHALL cover: collide_live set and a write to 0x46 in the frame_start cycle -> collide_rep=1.
REQ-033 SHALL cover: write RAM[2]=0x80 mid-frame -> player_x holds its old value until the cycle after vsync falls, then reads 0x80.
REQ-034 SHALL cover: 256 frame_starts from reset -> FRAME=0x00; async reset asserted mid-frame -> all outputs 0 immediately, before any clock edge.
